// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, fetch state encoding and branch-offset sign extension
package cpu_pkg;
  localparam int PC_W = 10;
  localparam int OFFSET_W = 16;
  localparam int MEM_DEPTH = 100;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam logic [5:0] OP_BR = 6'h10;
  localparam logic [5:0] OP_BMI = 6'h11;
  localparam logic [5:0] OP_BPL = 6'h12;
  localparam logic [5:0] OP_BZ = 6'h13;
  typedef enum logic [1:0] {RUN, HALT, FAULT} fetch_state_t;
  function automatic logic [PC_W-1:0] sext_off(input logic [OFFSET_W-1:0] off);
    return PC_W'(32'(signed'(off)));
  endfunction
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: next-PC mux (halt > branch > stall > advance) and out-of-range flag.
// The range check exists only when PC_BOUND_CHECK_EN is defined.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]     i_pc_reg,
  input  logic [PC_W-1:0]     i_branch_pc,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic                i_branch,
  input  logic                i_stall,
  input  logic                i_halt,
  output logic [PC_W-1:0]     o_next_pc,
  output logic                o_load,
  output logic                o_oor
);
  logic [PC_W-1:0] w_inc;
  logic [PC_W-1:0] w_tgt;
  always_comb begin
    w_inc = i_pc_reg + PC_W'(1);
    w_tgt = i_branch_pc + sext_off(i_offset);
    o_next_pc = i_halt ? i_pc_reg : i_branch ? w_tgt : i_stall ? i_pc_reg : w_inc;
    o_load = !i_halt && (i_branch || !i_stall);
  end
`ifdef PC_BOUND_CHECK_EN
  assign o_oor = o_load && (int'(o_next_pc) >= MEM_DEPTH);
`else
  assign o_oor = 1'b0;
`endif
endmodule

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: PC register and fetch control feeding a 1-cycle instruction memory.
// Optional out-of-range trap enabled by PC_BOUND_CHECK_EN.
module fetch_pc_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_pc,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic                halt_req,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     id_pc,
  output logic                id_valid,
  output logic                halted,
  output logic [31:0]         fetch_count,
  output logic                pc_fault
);
  fetch_state_t r_state, w_state_nx;
  logic [PC_W-1:0] r_pc, r_id_pc, w_next;
  logic r_id_valid, w_load, w_oor, w_run;
  logic [31:0] r_count;
  pc_next_calc u_next (
    .i_pc_reg   (r_pc),
    .i_branch_pc(branch_pc),
    .i_offset   (branch_offset),
    .i_branch   (branch_taken),
    .i_stall    (stall),
    .i_halt     (halt_req),
    .o_next_pc  (w_next),
    .o_load     (w_load),
    .o_oor      (w_oor)
  );
  assign w_run = r_state == RUN;
  // replaying id_pc during a stall keeps the memory output frozen
  assign pc = (stall && w_run) ? r_id_pc : r_pc;
  assign id_pc = r_id_pc;
  assign id_valid = r_id_valid;
  assign fetch_count = r_count;
  assign halted = !w_run;
  assign pc_fault = r_state == FAULT;
  always_comb w_state_nx = !w_run ? r_state : halt_req ? HALT : w_oor ? FAULT : RUN;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= RUN;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_id_pc <= RESET_PC;
      r_id_valid <= 1'b0;
      r_count <= '0;
    end else if (w_run) begin
      if (halt_req || w_oor) r_id_valid <= 1'b0;
      else if (w_load) begin
        r_pc <= w_next;
        r_id_pc <= r_pc;
        r_id_valid <= !branch_taken;
        r_count <= r_count + {31'b0, !branch_taken};
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: scoreboard bench with a behavioural fetch model and random stimulus.
module tb_fetch_pc_sequencer;
  import cpu_pkg::*;
  logic clk = 0, reset = 1, stall = 0, branch_taken = 0, halt_req = 0;
  logic [PC_W-1:0] branch_pc = '0;
  logic [OFFSET_W-1:0] branch_offset = '0;
  logic [PC_W-1:0] pc, id_pc;
  logic id_valid, halted, pc_fault;
  logic [31:0] fetch_count;
  always #5 clk = ~clk;
  fetch_pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_offset(branch_offset), .halt_req(halt_req),
    .pc(pc), .id_pc(id_pc), .id_valid(id_valid), .halted(halted),
    .fetch_count(fetch_count), .pc_fault(pc_fault)
  );
`ifdef PC_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif
  typedef struct packed {
    logic [PC_W-1:0] p;
    logic [PC_W-1:0] ip;
    logic v;
    logic h;
    logic f;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_pc, m_id_pc, m_mode;
  bit m_valid;
  logic [31:0] m_cnt;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  function automatic void m_reset();
    m_pc = 0; m_id_pc = 0; m_mode = 0; m_valid = 0; m_cnt = 0;
  endfunction
  function automatic bit m_bad(input int t);
    return BOUND && t >= MEM_DEPTH;
  endfunction
  function automatic void m_edge();
    int t;
    if (reset) m_reset();
    else if (m_mode == 0) begin
      if (halt_req) begin m_mode = 1; m_valid = 0; end
      else if (branch_taken || !stall) begin
        t = branch_taken ? (int'(branch_pc) + int'($signed(branch_offset))) % 1024 : (m_pc + 1) % 1024;
        if (t < 0) t += 1024;
        if (m_bad(t)) begin m_mode = 2; m_valid = 0; end
        else begin
          m_id_pc = m_pc;
          m_pc = t;
          m_valid = !branch_taken;
          if (!branch_taken) m_cnt = m_cnt + 1;
        end
      end
    end
  endfunction
  function automatic exp_t m_expect();
    exp_t e;
    e.p = PC_W'((m_mode == 0 && stall) ? m_id_pc : m_pc);
    e.ip = PC_W'(m_id_pc);
    e.v = m_valid;
    e.h = m_mode != 0;
    e.f = m_mode == 2;
    e.cnt = m_cnt;
    return e;
  endfunction
  task automatic step(input bit r, input bit s, input bit b, input int bpc, input int off, input bit h);
    @(posedge clk);
    #1;
    m_edge();
    reset = r; stall = s; branch_taken = b; halt_req = h;
    branch_pc = PC_W'(bpc);
    branch_offset = OFFSET_W'(off);
    if (r) m_reset();
    q.push_back(m_expect());
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", 32'(pc), 32'(e.p));
      chk("id_pc", 32'(id_pc), 32'(e.ip));
      chk("id_valid", 32'(id_valid), 32'(e.v));
      chk("halted", 32'(halted), 32'(e.h));
      chk("pc_fault", 32'(pc_fault), 32'(e.f));
      chk("fetch_count", fetch_count, e.cnt);
    end
  end
  initial begin
    m_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #1 chk("reset_pc", 32'(pc), 0);
    idle(4);
    #1 chk("boot_pc", 32'(pc), 4);
    chk("boot_id_pc", 32'(id_pc), 3);
    chk("boot_count", fetch_count, 4);
    idle(5);
    step(0, 0, 1, 9, -6, 0);
    step(0, 0, 0, 0, 0, 0);
    #1 chk("br_target", 32'(pc), 3);
    chk("br_squash", 32'(id_valid), 0);
    step(0, 0, 0, 0, 0, 0);
    #1 chk("br_first_valid", 32'(id_pc), 3);
    chk("br_valid_again", 32'(id_valid), 1);
    idle(20);
    repeat (3) begin
      step(0, 1, 0, 0, 0, 0);
      #1 chk("stall_pc", 32'(pc), 24);
      chk("stall_id_pc", 32'(id_pc), 24);
      chk("stall_count", fetch_count, 32);
    end
    step(0, 0, 0, 0, 0, 0);
    #1 chk("stall_release_pc", 32'(pc), 25);
    step(0, 1, 1, 24, 16, 0);
    step(0, 0, 0, 0, 0, 0);
    #1 chk("br_over_stall_pc", 32'(pc), 40);
    chk("br_over_stall_squash", 32'(id_valid), 0);
    step(0, 0, 0, 0, 0, 0);
    idle(16);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 3, 5, 0);
    #1 chk("halt_flag", 32'(halted), 1);
    chk("halt_pc", 32'(pc), 58);
    chk("halt_squash", 32'(id_valid), 0);
    step(0, 0, 0, 0, 0, 0);
    #1 chk("halt_ignores_branch", 32'(pc), 58);
    @(negedge clk);
    #2 reset = 1;
    #1 chk("async_reset_pc", 32'(pc), 0);
    chk("async_reset_halted", 32'(halted), 0);
    m_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 90, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 90, 15, 0);
    step(0, 0, 0, 0, 0, 0);
`ifdef PC_BOUND_CHECK_EN
    #1 chk("bound_pc_held", 32'(pc), 91);
    chk("bound_fault", 32'(pc_fault), 1);
    chk("bound_halted", 32'(halted), 1);
`else
    #1 chk("nobound_pc", 32'(pc), 105);
    chk("nobound_fault", 32'(pc_fault), 0);
    chk("nobound_halted", 32'(halted), 0);
`endif
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(199) == 0) || (m_mode != 0 && $urandom_range(19) == 0);
      step(r, $urandom_range(3) == 0, $urandom_range(9) == 0, m_id_pc,
           int'($urandom_range(80)) - 40, $urandom_range(299) == 0);
    end
    idle(2);
    @(negedge clk);
    #1 chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
